uart_cmd_dispatcher: RTL and testbench

UART_CMD_DISPATCHER -- requirements
Module: uart_cmd_dispatcher

---
 rtl/uart_cmd_dispatcher_if.sv | 27 ++
 rtl/uart_cmd_dispatcher.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_cmd_dispatcher.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_dispatcher_if.sv
// rtl/uart_cmd_dispatcher_if.sv - frame and engine handshake bundle for uart_cmd_dispatcher
interface uart_cmd_dispatcher_if #(
  parameter int FRAME_BYTES = 18,
  parameter int DATA_W      = 128
);
  logic [8*FRAME_BYTES-1:0] rx_frame;
  logic                     rx_valid;
  logic [8*FRAME_BYTES-1:0] tx_frame;
  logic                     tx_valid;
  logic                     tx_ready;
  logic [DATA_W-1:0]        eng_key;
  logic [DATA_W-1:0]        eng_text;
  logic                     eng_start;
  logic                     eng_done;
  logic [DATA_W-1:0]        eng_result;

  // master: UART link and engine side; slave: the dispatcher
  modport master (
    output rx_frame, rx_valid, tx_ready, eng_done, eng_result,
    input  tx_frame, tx_valid, eng_key, eng_text, eng_start
  );

  modport slave (
    input  rx_frame, rx_valid, tx_ready, eng_done, eng_result,
    output tx_frame, tx_valid, eng_key, eng_text, eng_start
  );
endinterface

// File: rtl/uart_cmd_dispatcher.sv
// rtl/uart_cmd_dispatcher.sv - framed UART command decoder driving a block engine with a result FIFO
module uart_cmd_dispatcher #(
  parameter int FRAME_BYTES = 18,
  parameter int DATA_W      = 128,
  parameter int RES_DEPTH   = 4,
  parameter int ENG_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_cmd_dispatcher_if.slave bus,
  output logic                 busy,
  output logic [7:0]           err_count
);
  localparam int FW = 8 * FRAME_BYTES;
  localparam int PW = $clog2(RES_DEPTH);
  localparam int TW = $clog2(ENG_TIMEOUT + 1);

  localparam logic [7:0] OP_KEY_WR  = 8'h4B;
  localparam logic [7:0] OP_TXT_WR  = 8'h50;
  localparam logic [7:0] OP_KEY_RD  = 8'h6B;
  localparam logic [7:0] OP_TXT_RD  = 8'h70;
  localparam logic [7:0] OP_ENGINE  = 8'h45;
  localparam logic [7:0] OP_RESULT  = 8'h52;
  localparam logic [7:0] OP_STATUS  = 8'h53;
  localparam logic [7:0] RSP_ACK    = 8'h41;
  localparam logic [7:0] RSP_ERR    = 8'h58;

  localparam logic [7:0] ERR_FRAME   = 8'h01;
  localparam logic [7:0] ERR_OPCODE  = 8'h02;
  localparam logic [7:0] ERR_FULL    = 8'h03;
  localparam logic [7:0] ERR_TIMEOUT = 8'h04;
  localparam logic [7:0] ERR_EMPTY   = 8'h06;

  typedef enum logic [1:0] {IDLE, DECODE, ENG_WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic [DATA_W-1:0] text_q, text_d;
  logic [PW:0]       wr_ptr_q, wr_ptr_d;
  logic [PW:0]       rd_ptr_q, rd_ptr_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [7:0]        err_q, err_d;
  logic [FW-1:0]     tx_frame_q, tx_frame_d;
  logic              tx_valid_q, tx_valid_d;
  logic              eng_start_q, eng_start_d;
  logic [DATA_W-1:0] mem_q [RES_DEPTH];

  logic              hdr_ok;
  logic [7:0]        opcode;
  logic [DATA_W-1:0] payload;
  logic [PW:0]       fifo_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              go_resp;
  logic              rsp_err;
  logic [7:0]        err_code;
  logic [7:0]        rsp_code;
  logic [FW-1:0]     rsp_body;
  logic              drop_evt;
  logic [1:0]        err_inc;
  logic [8:0]        err_sum;

  assign hdr_ok     = frame_q[7:0] == frame_q[FW-1 -: 8];
  assign opcode     = frame_q[7:0];
  assign payload    = frame_q[8 +: DATA_W];
  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = fifo_cnt == (PW+1)'(RES_DEPTH);
  assign fifo_empty = wr_ptr_q == rd_ptr_q;
  assign drop_evt   = bus.rx_valid && (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    key_d       = key_q;
    text_d      = text_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    tmo_d       = tmo_q;
    tx_frame_d  = tx_frame_q;
    tx_valid_d  = tx_valid_q;
    eng_start_d = 1'b0;
    push        = 1'b0;
    go_resp     = 1'b0;
    rsp_err     = 1'b0;
    err_code    = 8'h00;
    rsp_body    = '0;

    case (state_q)
      IDLE: begin
        if (bus.rx_valid) begin
          frame_d = bus.rx_frame;
          state_d = DECODE;
        end
      end

      DECODE: begin
        go_resp = 1'b1;
        if (!hdr_ok) begin
          rsp_err  = 1'b1;
          err_code = ERR_FRAME;
        end else begin
          case (opcode)
            OP_KEY_WR: key_d = payload;
            OP_TXT_WR: text_d = payload;
            OP_KEY_RD: rsp_body[8 +: DATA_W] = key_q;
            OP_TXT_RD: rsp_body[8 +: DATA_W] = text_q;
            OP_ENGINE: begin
              if (fifo_full) begin
                rsp_err  = 1'b1;
                err_code = ERR_FULL;
              end else begin
                go_resp     = 1'b0;
                eng_start_d = 1'b1;
                tmo_d       = '0;
                state_d     = ENG_WAIT;
              end
            end
            OP_RESULT: begin
              if (fifo_empty) begin
                rsp_err  = 1'b1;
                err_code = ERR_EMPTY;
              end else begin
                rsp_body[8 +: DATA_W] = mem_q[rd_ptr_q[PW-1:0]];
                rd_ptr_d = rd_ptr_q + 1'b1;
              end
            end
            OP_STATUS: begin
              rsp_body[15:8]  = 8'(fifo_cnt);
              rsp_body[23:16] = err_q;
            end
            default: begin
              rsp_err  = 1'b1;
              err_code = ERR_OPCODE;
            end
          endcase
        end
      end

      ENG_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (bus.eng_done) begin
          push     = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          go_resp  = 1'b1;
        end else if (tmo_q == TW'(ENG_TIMEOUT - 1)) begin
          go_resp  = 1'b1;
          rsp_err  = 1'b1;
          err_code = ERR_TIMEOUT;
        end
      end

      RESP: begin
        if (tx_valid_q && bus.tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Error responses carry only the code in byte1; everything else zero.
    rsp_code = rsp_err ? RSP_ERR : RSP_ACK;
    if (rsp_err) begin
      rsp_body       = '0;
      rsp_body[15:8] = err_code;
    end
    if (go_resp) begin
      state_d               = RESP;
      tx_valid_d            = 1'b1;
      tx_frame_d            = rsp_body;
      tx_frame_d[7:0]       = rsp_code;
      tx_frame_d[FW-1 -: 8] = rsp_code;
    end

    err_inc = {1'b0, go_resp && rsp_err} + {1'b0, drop_evt};
    err_sum = {1'b0, err_q} + {7'b0, err_inc};
    err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      key_q       <= '0;
      text_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tmo_q       <= '0;
      err_q       <= '0;
      tx_frame_q  <= '0;
      tx_valid_q  <= 1'b0;
      eng_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      key_q       <= key_d;
      text_q      <= text_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      tx_frame_q  <= tx_frame_d;
      tx_valid_q  <= tx_valid_d;
      eng_start_q <= eng_start_d;
    end
  end

  // Storage only; emptiness after reset comes from the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PW-1:0]] <= bus.eng_result;
    end
  end

  assign bus.tx_frame  = tx_frame_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.eng_key   = key_q;
  assign bus.eng_text  = text_q;
  assign bus.eng_start = eng_start_q;
  assign busy          = state_q != IDLE;
  assign err_count     = err_q;
endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// tb/tb_uart_cmd_dispatcher.sv - directed self-checking bench for uart_cmd_dispatcher
module tb_uart_cmd_dispatcher;
  localparam int FB    = 18;
  localparam int DW    = 128;
  localparam int DEPTH = 4;
  localparam int TMO   = 1024;
  localparam int FW    = 8 * FB;

  localparam logic [7:0] C_K = 8'h4B, C_P = 8'h50, C_k = 8'h6B, C_p = 8'h70;
  localparam logic [7:0] C_E = 8'h45, C_R = 8'h52, C_S = 8'h53, C_L = 8'h4C, C_Z = 8'h5A;
  localparam logic [7:0] C_A = 8'h41, C_X = 8'h58;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [7:0] err_count;

  int         n_tests;
  int         n_fail;
  int         cyc = 0;
  int         n_starts = 0;
  int         last_start_cyc = 0;
  bit         eng_auto;
  logic [DW-1:0] eng_val;
  logic          eng_done_r;
  logic          man_done;
  logic [DW-1:0] eng_res_r;
  logic [DW-1:0] vals [4];

  uart_cmd_dispatcher_if #(.FRAME_BYTES(FB), .DATA_W(DW)) bus ();

  uart_cmd_dispatcher #(
    .FRAME_BYTES(FB), .DATA_W(DW), .RES_DEPTH(DEPTH), .ENG_TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .bus       (bus),
    .busy      (busy),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.eng_start === 1'b1) begin
      n_starts       = n_starts + 1;
      last_start_cyc = cyc;
    end
  end

  assign bus.eng_done   = eng_done_r | man_done;
  assign bus.eng_result = eng_res_r;

  // Engine model: answers eng_start with eng_val two cycles later when enabled.
  initial begin
    eng_done_r = 1'b0;
    eng_res_r  = '0;
    forever begin
      @(negedge clk);
      if (bus.eng_start === 1'b1 && eng_auto) begin
        @(negedge clk);
        @(negedge clk);
        eng_res_r  = eng_val;
        eng_done_r = 1'b1;
        @(negedge clk);
        eng_done_r = 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] rsp(input logic [7:0] code, input logic [DW-1:0] body);
    logic [FW-1:0] f;
    f            = '0;
    f[7:0]       = code;
    f[8 +: DW]   = body;
    f[FW-1 -: 8] = code;
    return f;
  endfunction

  task automatic send(input logic [7:0] op, input logic [DW-1:0] pl, input logic [7:0] trl);
    logic [FW-1:0] f;
    f            = '0;
    f[7:0]       = op;
    f[8 +: DW]   = pl;
    f[FW-1 -: 8] = trl;
    bus.rx_frame = f;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 1;
    @(negedge clk);
    while (!bus.tx_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tx_valid) check_eq({tag, "_no_resp"}, 0, 1);
  endtask

  task automatic handshake(input string tag);
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
    check_eq({tag, "_txv_drop"}, bus.tx_valid, 0);
  endtask

  task automatic xact(input string tag, input logic [7:0] op, input logic [DW-1:0] pl,
                      input logic [7:0] trl, input logic [FW-1:0] exp, input int exp_lat);
    int n;
    send(op, pl, trl);
    wait_valid(tag, n);
    if (exp_lat > 0) check_eq({tag, "_lat"}, n, exp_lat);
    check_eq(tag, bus.tx_frame, exp);
    handshake(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int            n;
    int            bad;
    int            s0;
    logic [FW-1:0] held;

    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    man_done = 1'b0;
    eng_auto = 1'b1;
    eng_val  = '0;
    bus.rx_frame = '0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    vals[0] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    vals[1] = 128'hA5A5_A5A5_0000_0001_0000_0000_0000_0002;
    vals[2] = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE;
    vals[3] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    repeat (2) @(negedge clk);
    check_eq("reset_outputs", {busy, bus.tx_valid, bus.eng_start, err_count, bus.tx_frame}, '0);
    check_eq("reset_operands", {bus.eng_key, bus.eng_text}, '0);
    rst = 1'b0;
    @(negedge clk);

    xact("r_empty", C_R, '0, C_R, rsp(C_X, 128'h06), 1);
    check_eq("r_empty_err", err_count, 8'd1);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_err_clear", err_count, 8'd0);

    xact("k_wr", C_K, '0, C_K, rsp(C_A, '0), 1);
    xact("p_wr", C_P, 128'hf34481ec3cc627bacd5dc3fb08f273e6, C_P, rsp(C_A, '0), 1);
    check_eq("eng_text", bus.eng_text, 128'hf34481ec3cc627bacd5dc3fb08f273e6);
    xact("p_rd", C_p, '0, C_p, rsp(C_A, 128'hf34481ec3cc627bacd5dc3fb08f273e6), 1);
    xact("k_rd", C_k, '0, C_k, rsp(C_A, '0), 1);
    eng_val = 128'h0336763e966d92595a567cc9ce537f5e;
    xact("e_run", C_E, '0, C_E, rsp(C_A, '0), 0);
    xact("s_one", C_S, '0, C_S, rsp(C_A, 128'h0001), 1);
    xact("r_pop", C_R, '0, C_R, rsp(C_A, 128'h0336763e966d92595a567cc9ce537f5e), 1);
    xact("s_zero", C_S, '0, C_S, rsp(C_A, '0), 1);

    xact("bad_trailer", C_K, 128'h1111, C_L, rsp(C_X, 128'h01), 1);
    check_eq("bad_trailer_err", err_count, 8'd1);
    check_eq("bad_trailer_key", bus.eng_key, '0);
    xact("bad_opcode", C_Z, '0, C_Z, rsp(C_X, 128'h02), 1);
    check_eq("bad_opcode_err", err_count, 8'd2);

    for (int i = 0; i < 4; i++) begin
      eng_val = vals[i];
      xact($sformatf("e_fill%0d", i), C_E, '0, C_E, rsp(C_A, '0), 0);
    end
    s0 = n_starts;
    xact("e_full", C_E, '0, C_E, rsp(C_X, 128'h03), 1);
    check_eq("e_full_no_start", n_starts, s0);
    xact("s_full", C_S, '0, C_S, rsp(C_A, 128'h0304), 1);
    xact("r_oldest", C_R, '0, C_R, rsp(C_A, vals[0]), 1);

    eng_auto = 1'b0;
    send(C_E, '0, C_E);
    wait_valid("tmo", n);
    check_eq("tmo_cycles", cyc - last_start_cyc, TMO);
    check_eq("tmo_frame", bus.tx_frame, rsp(C_X, 128'h04));
    handshake("tmo");

    send(C_S, '0, C_S);
    wait_valid("hold", n);
    held = bus.tx_frame;
    check_eq("hold_frame", held, rsp(C_A, 128'h0403));
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) send(C_K, 128'hDEAD, C_K);
      else @(negedge clk);
      if (bus.tx_frame !== held || bus.tx_valid !== 1'b1) bad++;
    end
    check_eq("hold_stable", bad, 0);
    check_eq("drop_err", err_count, 8'd5);
    handshake("hold");
    repeat (3) @(negedge clk);
    check_eq("drop_no_resp", bus.tx_valid, 0);
    xact("drop_key_kept", C_k, '0, C_k, rsp(C_A, '0), 1);

    send(C_E, '0, C_E);
    repeat (3) @(negedge clk);
    check_eq("ew_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_ew_outputs", {busy, bus.tx_valid, bus.eng_start, err_count, bus.tx_frame}, '0);
    check_eq("rst_ew_operands", {bus.eng_key, bus.eng_text}, '0);
    rst = 1'b0;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("late_done_ignored", {busy, bus.tx_valid}, 0);
    xact("post_rst_s", C_S, '0, C_S, rsp(C_A, '0), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
